// File: rtl/output_interface_pkg.sv
// Shared router definitions: port directions, indices, default widths.
// Common to the input interface, routing logic and output interface.
package output_interface_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int NUM_PORTS      = 5;

    localparam logic [4:0] DIR_L  = 5'b10000;
    localparam logic [4:0] DIR_R  = 5'b01000;
    localparam logic [4:0] DIR_U  = 5'b00100;
    localparam logic [4:0] DIR_D  = 5'b00010;
    localparam logic [4:0] DIR_PE = 5'b00001;

    localparam int IDX_L  = 4;
    localparam int IDX_R  = 3;
    localparam int IDX_U  = 2;
    localparam int IDX_D  = 1;
    localparam int IDX_PE = 0;

    // One-hot of the most significant set bit (0 when v is 0).
    function automatic logic [4:0] hi_onehot(input logic [4:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (v[i]) begin
                r = 5'd1 << i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/output_interface_rr_arbiter5.sv
// Five-way round-robin arbiter, descending search below the last winner.
// Grant is combinational; the winner is remembered only when enabled.
module rr_arbiter5
    import output_interface_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] req,
    input  logic       en,
    output logic [4:0] gnt
);

    logic [4:0] last_gnt_q;
    logic [4:0] last_gnt_d;
    logic [4:0] below;
    logic [4:0] pick;

    // Prefer requesters strictly below the last winner, else wrap to the top.
    always_comb begin
        below      = req & (last_gnt_q - 5'd1);
        pick       = (below != 5'd0) ? hi_onehot(below) : hi_onehot(req);
        gnt        = en ? pick : 5'd0;
        last_gnt_d = (|gnt) ? gnt : last_gnt_q;
    end

    // Remember the winner; reset to PE so L has first priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt_q <= DIR_PE;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/output_interface.sv
// Router output port: round-robin pick of routed flits into a small FIFO,
// driven to the neighbour with a send/ready handshake.
module output_interface
    import output_interface_pkg::*;
#(
    parameter int         DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter logic [4:0] DIRECTION    = DIR_L,
    parameter int         BUFFER_DEPTH = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4:0]                req_in,
    input  logic [5*DATA_WIDTH-1:0]   data_in,
    output logic [4:0]                gnt,
    output logic                      so,
    input  logic                      ri,
    output logic [DATA_WIDTH-1:0]     datao
);

    localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
    localparam int SLOTS = 1 << PTR_W;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUFFER_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUFFER_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [SLOTS];
    logic [DATA_WIDTH-1:0] hold_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      wr_ptr_d;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  pop;
    logic                  push;
    logic                  space;
    logic                  unused_dir;

    assign unused_dir = ^DIRECTION;

    // A full FIFO still accepts a flit when the head leaves at the same edge.
    assign so    = (count_q != '0);
    assign pop   = so & ri;
    assign space = (count_q < CNT_FULL) | pop;
    assign push  = |gnt;

    // While empty, keep showing the last flit that left.
    assign datao = so ? mem_q[rd_ptr_q] : hold_q;

    // rst gating keeps the grant, and so every source buffer, quiet in reset.
    rr_arbiter5 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_in),
        .en  (space & rst),
        .gnt (gnt)
    );

    // Select the winning slice; the grant is one-hot so OR-ing is exact.
    always_comb begin
        wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt[i]) begin
                wdata = wdata | data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next pointer and occupancy values.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer, occupancy and last-output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (pop) begin
                hold_q <= mem_q[rd_ptr_q];
            end
        end
    end

    // FIFO storage; the granted flit is written at the tail.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: doc/output_interface.md
# output_interface

Per-direction output port of the mesh router: the transmit-side counterpart of the router's input interfaces. It collects routed flits from the five input ports (L, R, U, D, PE), picks one per cycle with a round-robin arbiter, and holds it in a small output FIFO. It drives the si/ri-style send/ready handshake toward the neighbouring router's input interface, or toward the local PE. It returns a one-hot grant so the winning input port can clear its channel buffer (`sig_buffer_clear`).

## Interface
- `DATA_WIDTH`, 64, flit width.
- `DIRECTION`, 5'b10000, one-hot output direction this instance drives (L:10000, R:01000, U:00100, D:00010, PE:00001); informational, no logic effect.
- `BUFFER_DEPTH`, 1, output FIFO entries (≥1).

- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_in`  in  5  one bit per source input port; bit 4=L, 3=R, 2=U, 1=D, 0=PE.
- `data_in`  in  5*DATA_WIDTH  flattened flits; slice k = `data_in[k*DATA_WIDTH +: DATA_WIDTH]`, same bit mapping as `req_in`.
- `gnt`  out  5  one-hot grant to source k; wired to that port's `sig_buffer_clear`.
- `so`  out  1  send-out: a valid flit is on `datao`.
- `ri`  in  1  downstream ready (receiver's buffer not full).
- `datao`  out  DATA_WIDTH  head-of-FIFO flit.

## Operation
- **Pop:** `pop = so & ri`. At that edge the head entry leaves and the receiver latches it.
- **Space:** `space = (count < BUFFER_DEPTH) | pop`. Push and pop at the same edge while full is legal; count stays unchanged.
- **Arbitration:** combinational, qualified by `space`. If `space` and `req_in != 0`, exactly one `gnt` bit is set. Otherwise `gnt = 0`.
- **Round-robin order:** search starts at the bit below `last_gnt` and descends: 4→3→2→1→0→4. The first requesting bit wins.
- **Push:** `push = |gnt`. At the edge, the winning slice is written to the tail and `last_gnt` updates to the winner. `last_gnt` is unchanged on cycles with no grant.
- **Source side:** the granted source clears or advances its buffer at the same edge. A source whose `req_in` stays high without a grant holds its data stable.
- **Outputs:** `so = (count != 0)`; `datao` = head entry. When empty, `datao` holds its last value; it is 0 after reset.
- **FIFO structure:** circular buffer with read and write pointers of width `$clog2(BUFFER_DEPTH)` (min 1). Pointers wrap from `BUFFER_DEPTH-1` to 0. `count` runs 0..`BUFFER_DEPTH`.
- **Reset values:**
  - `count=0`, pointers 0, all FIFO entries 0.
  - `last_gnt=5'b00001`, so after reset L has first priority.
  - `so=0`, `datao=0`, `gnt=0`.
  - `gnt` is forced to 0 while `rst` is low.
- **Reset mid-operation:** buffered flits are discarded. No grant is issued during reset, so no source buffer is cleared.
- `req_in` bits for U-turn directions are not filtered here; the routing logic never produces them.

## Timing
- Grant latency: 0 cycles. `gnt` is valid in the same cycle as `req_in`.
- Flit latency: granted at edge N → `so=1`, `datao` valid after edge N → earliest pop at edge N+1.
- Throughput: 1 flit/cycle with `ri` held high, at any `BUFFER_DEPTH`, via the full push+pop path.
- `ri` low: the FIFO fills. Once `count == BUFFER_DEPTH`, `gnt=0` until the cycle in which `ri=1`.
- Back-to-back grants to the same source are allowed only when no other source requests.

## Structure
- **Shared package:** direction one-hot constants (`DIR_L`…`DIR_PE`), index constants (`IDX_L=4`…`IDX_PE=0`), default `DATA_WIDTH`. These are common with the input interface and routing algorithm.
- **Sub-module `rr_arbiter5`:** inputs `clk`, `rst`, `req[4:0]`, `en`; output `gnt[4:0]`. Holds `last_gnt` and updates it on `en & |gnt`.
- **Inline:** the FIFO stays in `output_interface`.

## Test plan
- **Reset:** `rst` low with `req_in=5'b11111` → `gnt=0`, `so=0`, `datao=0`. After release, first grant is `gnt=5'b10000` (L).
- **Single source, depth 1:** `req_in=5'b00001` with PE data `64'hA5`, `ri=1` → `gnt=00001` at cycle 0; `so=1`, `datao=64'hA5` at cycle 1; popped at edge 2.
- **Fairness:** all five request continuously, `ri=1` → grants cycle 10000, 01000, 00100, 00010, 00001, 10000; each source wins 2 of 10 cycles.
- **Backpressure, depth 2:** `ri=0`, L and U request → two grants (L then U), then `gnt=0`, `so=1`. Raise `ri` → `gnt` asserts that same cycle; pops deliver L data then U data, in order.
- **Full + simultaneous:** depth 1, full, `ri=1`, `req_in=00010` → pop and push at the same edge; `count` stays 1; `datao` switches to D's flit next cycle.
- **Mid-operation reset:** depth 2 holding 2 flits, assert `rst` → `so=0` immediately (asynchronous). After release, `last_gnt` is back to PE, so L wins first.
